// File: rtl/vga_controller.sv
// VGA raster timing generator: pixel/line counters with registered sync, blank
// and line/frame pulses aligned to DrawX/DrawY, plus a wrapping frame counter.
`timescale 1ns/1ps
module vga_controller #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        run,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic        sync,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_MAX      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS      = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_SYNC_LO  = HW'(H_VISIBLE + H_FP);
    localparam logic [HW-1:0] H_SYNC_HI  = HW'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_MAX      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS      = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_SYNC_LO  = VW'(V_VISIBLE + V_FP);
    localparam logic [VW-1:0] V_SYNC_HI  = VW'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          running_q, running_d;
    logic          hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
    logic          line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic [15:0]   frame_count_q, frame_count_d;

    // running_q distinguishes the resume edge (present origin) from normal advance.
    always_comb begin
        running_d     = run;
        h_d           = '0;
        v_d           = '0;
        frame_count_d = frame_count_q;
        if (run && running_q) begin
            if (h_q == H_MAX) begin
                if (v_q == V_MAX) begin
                    frame_count_d = frame_count_q + 16'd1;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
                v_d = v_q;
            end
        end
    end

    // Decode the next counter values so registered outputs line up with DrawX/DrawY.
    always_comb begin
        hs_d          = !(running_d && (h_d >= H_SYNC_LO) && (h_d <= H_SYNC_HI));
        vs_d          = !(running_d && (v_d >= V_SYNC_LO) && (v_d <= V_SYNC_HI));
        blank_d       = running_d && (h_d < H_VIS) && (v_d < V_VIS);
        line_start_d  = running_d && (h_d == '0);
        frame_start_d = running_d && (h_d == '0) && (v_d == '0);
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            h_q           <= '0;
            v_q           <= '0;
            running_q     <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            running_q     <= running_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign DrawX       = 10'(h_q);
    assign DrawY       = 10'(v_q);
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank       = blank_q;
    assign sync        = 1'b0;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;
endmodule
